// File: rtl/placement_anneal_sched_pkg.sv
// Shared types and constants for the placement annealing blocks.
// Holds the scheduler state encoding, the LFSR polynomial and the cell-count helper.
package placement_anneal_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK_A,
        S_PICK_B,
        S_ISSUE,
        S_WAIT_COST,
        S_COMMIT,
        S_COOL,
        S_DONE
    } anneal_state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    function automatic int cell_count(input int grid);
        return grid * grid;
    endfunction

endpackage

// File: rtl/placement_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous load and advance enable.
// A zero seed would lock the register, so it is replaced by 1.
module placement_lfsr32
    import placement_anneal_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] lfsr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 32'h1;
        end else if (load) begin
            lfsr <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (adv) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/placement_anneal_sched.sv
// Simulated-annealing scheduler: draws random cell pairs, issues swap proposals,
// accepts or rejects returned cost deltas against the temperature, and cools it.
module placement_anneal_sched
    import placement_anneal_sched_pkg::*;
#(
    parameter int grid_size   = 9,
    parameter int cell_width  = 7,
    parameter int rand_width  = 4,
    parameter int cost_width  = 16,
    parameter int temp_width  = 16,
    parameter int iter_width  = 16,
    parameter int decay_shift = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         loadseed,
    input  logic [31:0]                  seed,
    input  logic [temp_width-1:0]        t_init,
    input  logic [temp_width-1:0]        t_min,
    input  logic [iter_width-1:0]        iters_per_temp,
    output logic                         swp_valid,
    input  logic                         swp_ready,
    output logic [cell_width-1:0]        swp_a,
    output logic [cell_width-1:0]        swp_b,
    input  logic                         cost_valid,
    input  logic signed [cost_width-1:0] cost_delta,
    output logic                         commit_valid,
    output logic                         commit_accept,
    input  logic                         commit_ready,
    output logic                         busy,
    output logic                         done,
    output logic [temp_width-1:0]        temp,
    output logic [31:0]                  accept_cnt
);

    localparam int cells = cell_count(grid_size);
    localparam logic [cell_width:0] cells_lim = (cell_width + 1)'(cells);
    localparam int cmp_w = (cost_width > temp_width) ? cost_width : temp_width;

    anneal_state_t state_q, state_d;

    logic [31:0]           lfsr;
    logic                  lfsr_adv;
    logic                  lfsr_load;
    logic [cell_width-1:0] cand;
    logic                  cand_ok_a;
    logic                  cand_ok_b;
    logic                  unused_lfsr_hi;

    logic [temp_width-1:0] t_min_q;
    logic [iter_width-1:0] iters_q;
    logic [iter_width-1:0] iter_q;
    logic [iter_width-1:0] iter_last;
    logic                  accept_q;
    logic [temp_width-1:0] temp_step;
    logic [temp_width-1:0] temp_cooled;

    // Positive deltas compare unsigned against the randomly scaled temperature.
    function automatic logic decide_accept(input logic signed [cost_width-1:0] delta,
                                           input logic [temp_width-1:0]        t,
                                           input logic [rand_width-1:0]        sh);
        logic [cmp_w-1:0] d_mag;
        logic [cmp_w-1:0] thr;
        d_mag = cmp_w'($unsigned(delta));
        thr   = cmp_w'(t >> sh);
        if (delta[cost_width-1] || (delta == '0)) begin
            return 1'b1;
        end
        return d_mag < thr;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
        return (&cnt) ? cnt : cnt + 32'd1;
    endfunction

    placement_lfsr32 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (seed),
        .adv  (lfsr_adv),
        .lfsr (lfsr)
    );

    assign cand           = lfsr[cell_width-1:0];
    assign cand_ok_a      = {1'b0, cand} < cells_lim;
    assign cand_ok_b      = cand_ok_a && (cand != swp_a);
    assign unused_lfsr_hi = ^lfsr[31:cell_width];

    // An iteration count of zero behaves as one proposal per temperature.
    assign iter_last = (iters_q == '0) ? '0 : iters_q - iter_width'(1);

    always_comb begin
        temp_step = temp >> decay_shift;
        if (temp_step == '0) begin
            temp_step = temp_width'(1);
        end
        temp_cooled = (temp >= temp_step) ? temp - temp_step : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lfsr_adv     = 1'b0;
        lfsr_load    = 1'b0;
        swp_valid    = 1'b0;
        commit_valid = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (loadseed) begin
                    lfsr_load = 1'b1;
                end else if (start) begin
                    state_d = (t_init < t_min) ? S_DONE : S_PICK_A;
                end
            end
            S_PICK_A: begin
                lfsr_adv = 1'b1;
                if (cand_ok_a) state_d = S_PICK_B;
            end
            S_PICK_B: begin
                lfsr_adv = 1'b1;
                if (cand_ok_b) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                swp_valid = 1'b1;
                if (swp_ready) state_d = S_WAIT_COST;
            end
            S_WAIT_COST: begin
                if (cost_valid) begin
                    lfsr_adv = 1'b1;
                    state_d  = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit_valid = 1'b1;
                if (commit_ready) state_d = (iter_q == iter_last) ? S_COOL : S_PICK_A;
            end
            S_COOL: begin
                state_d = (temp_cooled < t_min_q) ? S_DONE : S_PICK_A;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_min_q    <= '0;
            iters_q    <= '0;
            iter_q     <= '0;
            temp       <= '0;
            accept_cnt <= '0;
            swp_a      <= '0;
            swp_b      <= '0;
            accept_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!loadseed && start) begin
                        t_min_q    <= t_min;
                        iters_q    <= iters_per_temp;
                        temp       <= t_init;
                        iter_q     <= '0;
                        accept_cnt <= '0;
                    end
                end
                S_PICK_A: if (cand_ok_a) swp_a <= cand;
                S_PICK_B: if (cand_ok_b) swp_b <= cand;
                S_WAIT_COST: begin
                    if (cost_valid) begin
                        accept_q <= decide_accept(cost_delta, temp, lfsr[rand_width-1:0]);
                    end
                end
                S_COMMIT: begin
                    if (commit_ready) begin
                        if (accept_q) accept_cnt <= sat_inc32(accept_cnt);
                        iter_q <= iter_q + iter_width'(1);
                    end
                end
                S_COOL: begin
                    temp   <= temp_cooled;
                    iter_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign commit_accept = commit_valid & accept_q;

endmodule

// File: tb/tb_placement_anneal_sched.sv
// Directed bench for placement_anneal_sched: acts as the swap engine and predicts
// every pair, decision and temperature from its own LFSR and cooling model.
module tb_placement_anneal_sched;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               loadseed = 1'b0;
    logic [31:0]        seed = '0;
    logic [15:0]        t_init = '0;
    logic [15:0]        t_min = '0;
    logic [15:0]        iters_per_temp = '0;
    logic               swp_ready = 1'b0;
    logic               cost_valid = 1'b0;
    logic signed [15:0] cost_delta = '0;
    logic               commit_ready = 1'b0;

    logic               swp_valid;
    logic [6:0]         swp_a;
    logic [6:0]         swp_b;
    logic               commit_valid;
    logic               commit_accept;
    logic               busy;
    logic               done;
    logic [15:0]        temp;
    logic [31:0]        accept_cnt;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_lfsr = 32'h1;
    int          m_temp = 0;
    int          m_acc = 0;
    int          q_pair[$];
    int          q_acc[$];
    int          delta_tab[7] = '{3, -2, 40, 0, 9, 100, 1};

    placement_anneal_sched dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .loadseed       (loadseed),
        .seed           (seed),
        .t_init         (t_init),
        .t_min          (t_min),
        .iters_per_temp (iters_per_temp),
        .swp_valid      (swp_valid),
        .swp_ready      (swp_ready),
        .swp_a          (swp_a),
        .swp_b          (swp_b),
        .cost_valid     (cost_valid),
        .cost_delta     (cost_delta),
        .commit_valid   (commit_valid),
        .commit_accept  (commit_accept),
        .commit_ready   (commit_ready),
        .busy           (busy),
        .done           (done),
        .temp           (temp),
        .accept_cnt     (accept_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict the next proposed pair from the model LFSR and push it to the scoreboard.
    task automatic predict_pair();
        int a;
        int b;
        int c;
        a = -1;
        while (a < 0) begin
            c = int'(m_lfsr[6:0]);
            m_lfsr = lfsr_next(m_lfsr);
            if (c < 81) a = c;
        end
        b = -1;
        while (b < 0) begin
            c = int'(m_lfsr[6:0]);
            m_lfsr = lfsr_next(m_lfsr);
            if (c < 81 && c != a) b = c;
        end
        q_pair.push_back(a);
        q_pair.push_back(b);
    endtask

    task automatic serve_one(input int delta, input int swp_wait, input int com_wait);
        int         cyc;
        int         bad;
        int         ea;
        int         eb;
        int         shift;
        int         exp_acc;
        logic [6:0] ha;
        logic [6:0] hb;
        logic       hacc;
        predict_pair();
        cyc = 0;
        while (swp_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("swp_valid_wait", 32'(swp_valid), 32'd1);
        if (swp_valid !== 1'b1) return;
        chk("temp_at_issue", 32'(temp), m_temp);
        ha  = swp_a;
        hb  = swp_b;
        bad = 0;
        for (int i = 0; i < swp_wait; i++) begin
            cost_valid = (i == 0);
            cost_delta = 16'sd1;
            @(negedge clk);
            cost_valid = 1'b0;
            if (swp_valid !== 1'b1 || swp_a !== ha || swp_b !== hb) bad++;
        end
        if (swp_wait > 0) chk("swp_hold", bad, 0);
        ea = q_pair.pop_front();
        eb = q_pair.pop_front();
        chk("swp_a", 32'(swp_a), ea);
        chk("swp_b", 32'(swp_b), eb);
        chk("pair_legal", 32'(swp_a != swp_b && swp_a < 81 && swp_b < 81), 32'd1);
        swp_ready = 1'b1;
        @(negedge clk);
        swp_ready = 1'b0;
        chk("swp_valid_drop", 32'(swp_valid), 32'd0);
        shift   = int'(m_lfsr[3:0]);
        exp_acc = (delta <= 0 || delta < (m_temp >> shift)) ? 1 : 0;
        q_acc.push_back(exp_acc);
        m_lfsr = lfsr_next(m_lfsr);
        cost_valid = 1'b1;
        cost_delta = 16'(delta);
        @(negedge clk);
        cost_valid = 1'b0;
        cyc = 0;
        while (commit_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("commit_valid_wait", 32'(commit_valid), 32'd1);
        if (commit_valid !== 1'b1) return;
        hacc = commit_accept;
        bad  = 0;
        for (int i = 0; i < com_wait; i++) begin
            @(negedge clk);
            if (commit_valid !== 1'b1 || commit_accept !== hacc || swp_valid !== 1'b0) bad++;
        end
        if (com_wait > 0) chk("commit_hold", bad, 0);
        exp_acc = q_acc.pop_front();
        chk("commit_accept", 32'(commit_accept), exp_acc);
        commit_ready = 1'b1;
        @(negedge clk);
        commit_ready = 1'b0;
        if (exp_acc != 0) m_acc++;
    endtask

    task automatic run_anneal(input bit do_load, input logic [31:0] sd, input int ti, input int tm,
                              input int it, input bit use_tab, input int dfix,
                              input int sw, input int cw);
        int k;
        int step;
        int cyc;
        if (do_load) begin
            loadseed = 1'b1;
            seed     = sd;
            @(negedge clk);
            loadseed = 1'b0;
            m_lfsr   = (sd == 0) ? 32'h1 : sd;
        end
        t_init         = 16'(ti);
        t_min          = 16'(tm);
        iters_per_temp = 16'(it);
        start          = 1'b1;
        @(negedge clk);
        m_temp = ti;
        m_acc  = 0;
        k      = 0;
        chk("busy_run", 32'(busy), 32'd1);
        while (m_temp >= tm) begin
            for (int i = 0; i < ((it == 0) ? 1 : it); i++) begin
                serve_one(use_tab ? delta_tab[k % 7] : dfix, sw, cw);
                k++;
            end
            step = m_temp >> 3;
            if (step == 0) step = 1;
            m_temp = (m_temp >= step) ? m_temp - step : 0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_set", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("temp_final", 32'(temp), m_temp);
        chk("accept_cnt", accept_cnt, m_acc);
        start = 1'b0;
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int bad;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_swp_valid", 32'(swp_valid), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_temp", 32'(temp), 32'd0);
        chk("rst_accept_cnt", accept_cnt, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Start floor above t_init: straight to DONE, no proposal.
        t_init = 16'd10;
        t_min  = 16'd20;
        iters_per_temp = 16'd1;
        start  = 1'b1;
        bad    = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (swp_valid !== 1'b0) bad++;
        end
        chk("direct_no_swp", bad, 0);
        chk("direct_done", 32'(done), 32'd1);
        chk("direct_busy", 32'(busy), 32'd0);
        chk("direct_temp", 32'(temp), 32'd10);
        start = 1'b0;
        @(negedge clk);
        chk("direct_idle", 32'(done), 32'd0);

        // Zero seed loads as 1; mixed deltas.
        run_anneal(1'b1, 32'h0, 100, 50, 1, 1'b1, 0, 0, 0);

        // Always-negative deltas: 64->56->49->43->38, 16 commits.
        run_anneal(1'b1, 32'hC0FFEE11, 64, 40, 4, 1'b0, -5, 0, 0);
        chk("neg_accept16", accept_cnt, 32'd16);
        chk("neg_temp38", 32'(temp), 32'd38);

        // Large positive delta never accepted.
        run_anneal(1'b1, 32'h12345678, 64, 60, 8, 1'b0, 1000, 0, 0);
        chk("pos_accept0", accept_cnt, 32'd0);

        // Small temperature: forced unit step, with stalled handshakes.
        run_anneal(1'b1, 32'hA5A55A5A, 5, 2, 1, 1'b0, 2, 10, 7);
        chk("small_temp1", 32'(temp), 32'd1);

        // Reset in the middle of a COMMIT.
        t_init = 16'd64;
        t_min  = 16'd10;
        iters_per_temp = 16'd2;
        start  = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (swp_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_swp", 32'(swp_valid), 32'd1);
        swp_ready = 1'b1;
        @(negedge clk);
        swp_ready  = 1'b0;
        cost_valid = 1'b1;
        cost_delta = -16'sd1;
        @(negedge clk);
        cost_valid = 1'b0;
        cyc = 0;
        while (commit_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_commit", 32'(commit_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_commit_valid", 32'(commit_valid), 32'd0);
        chk("rstmid_swp_valid", 32'(swp_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_temp", 32'(temp), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_lfsr = 32'h1;
        @(negedge clk);
        chk("rstmid_idle_busy", 32'(busy), 32'd0);
        chk("rstmid_idle_done", 32'(done), 32'd0);

        // After reset the LFSR restarts from 1 without a seed load.
        run_anneal(1'b0, 32'h0, 100, 90, 1, 1'b0, -3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/placement_anneal_sched.md
Name: placement_anneal_sched

Overview:
- Simulated-annealing scheduler that sequences the placement swap engine.
- Draws random cell pairs from an internal LFSR and issues them as swap proposals.
- Takes the returned cost delta, decides accept or reject against the current temperature, and commits the decision.
- Cools the temperature after a fixed number of proposals; signals done when the temperature falls below a floor. Sits between the top-level start/seed control and the swap/cost datapath.

Parameters:
- grid_size, 9: grid side; number of cells = grid_size*grid_size (81).
- cell_width, 7: cell index width; must satisfy 2^cell_width >= cells.
- rand_width, 4: LFSR bits used as the acceptance shift amount.
- cost_width, 16: signed cost-delta width.
- temp_width, 16: unsigned temperature width.
- iter_width, 16: proposals-per-temperature counter width.
- decay_shift, 3: cooling step; temp -= temp>>decay_shift.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; run request
- loadseed  in  1  load seed into LFSR (IDLE only)
- seed  in  32  LFSR seed
- t_init  in  temp_width  start temperature, latched on start
- t_min  in  temp_width  stop floor, latched on start
- iters_per_temp  in  iter_width  proposals per temperature, latched on start
- swp_valid  out  1  swap proposal valid
- swp_ready  in  1  swap engine accepts proposal
- swp_a  out  cell_width  first cell
- swp_b  out  cell_width  second cell
- cost_valid  in  1  cost delta valid (single-cycle pulse)
- cost_delta  in  cost_width  signed cost change of the proposal
- commit_valid  out  1  decision valid
- commit_accept  out  1  1 = keep swap, 0 = undo
- commit_ready  in  1  swap engine took the decision
- busy  out  1  not in IDLE or DONE
- done  out  1  annealing finished
- temp  out  temp_width  current temperature
- accept_cnt  out  32  accepted swaps this run (saturating)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; LFSR=32'h1.
- LFSR: 32-bit Galois, taps 32'h80200003, shifts right; it advances only in PICK_A, PICK_B and on cost_valid in WAIT_COST. A seed of 0 loads as 1.
- IDLE: loadseed=1 loads the LFSR. Otherwise, start=1 latches the config, sets temp=t_init, iter=0, accept_cnt=0, and goes to PICK_A. If t_init < t_min, go to DONE instead.
- PICK_A: cand = lfsr[cell_width-1:0]; advance the LFSR. If cand < cells, store it as swp_a and go to PICK_B; else stay.
- PICK_B: same draw; accept the candidate only if it is < cells and != swp_a, store it as swp_b, and go to ISSUE.
- ISSUE: swp_valid=1 with swp_a/swp_b stable until swp_ready; the handshake cycle drops swp_valid next cycle and goes to WAIT_COST.
- WAIT_COST: on cost_valid, accept = (cost_delta <= 0) OR (cost_delta < (temp >> lfsr[rand_width-1:0])), with the positive delta compared unsigned against the zero-extended threshold. Register the decision, advance the LFSR, and go to COMMIT. A cost_valid arriving in any other state is ignored.
- COMMIT: commit_valid=1 and commit_accept held until commit_ready.
  - On handshake: accept_cnt += accept (saturate at all-ones); iter += 1.
  - If iter == max(iters_per_temp,1)-1, go to COOL; else go to PICK_A.
- COOL (1 cycle): step = temp>>decay_shift, forced to 1 if 0; temp -= step (floor 0); iter=0. Go to DONE if the new temp < t_min; else go to PICK_A.
- DONE: done=1 and busy=0, held while start=1. When start=0, return to IDLE next cycle; done clears there.
- start deassertion mid-run is ignored; only reset aborts a run. loadseed outside IDLE is ignored.
- The proposal-to-decision minimum is 4 cycles plus the handshake waits; exactly one proposal is outstanding at a time.

Decomposition:
- Shared package: state enum, LFSR tap constant, cells = grid_size*grid_size.
- Sub-module placement_lfsr32: load, advance enable, and the 32-bit state output; reused by other placement blocks.

Test Plan:
- Reset mid-COMMIT with commit_valid=1 -> commit_valid, swp_valid, busy, done and temp are 0 within the same cycle as reset assertion; state is IDLE after release.
- seed=0, loadseed, start with t_init=100, t_min=50, iters=1 -> LFSR starts at 1; every issued pair satisfies swp_a != swp_b and both < 81.
- Always-negative cost_delta=-5, iters=4, t_init=64, t_min=40, decay_shift=3 -> temps 64→56→49→43→38; done after 16 commits; accept_cnt=16.
- cost_delta=+1000 with temp=64 -> commit_accept=0 for every shift value; accept_cnt stays 0.
- t_init=5, decay_shift=3 -> step forced to 1: temps 5,4,3...; with t_min=2, done once temp=1.
- swp_ready held low 10 cycles, then commit_ready low 7 cycles -> swp_a/swp_b and commit_accept are stable while waiting, with no second proposal issued.
- t_init=10, t_min=20 -> DONE directly from IDLE, no swp_valid; start low -> IDLE next cycle.
